alien_row_renderer: RTL

- Pixel-writing stage directly downstream of the alien talent manager.
- Consumes its kill1..kill5 and moveDown requests and serially plots pixels into the VGA frame-buffer adapter to erase dead aliens and redraw the row lower after a drop.
- Returns one-cycle cleared1..cleared5 and clearedShift acknowledgements.
- Owns the row's alive mask and current top Y. The manager's coordinate outputs are not used.

---
 rtl/alien_row_renderer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alien_row_renderer.sv
// alien_row_renderer
// Pixel-writing stage behind the alien talent manager. Serially plots one pixel per cycle into the
// VGA frame-buffer adapter: draws the row after reset, erases killed aliens and redraws the whole
// row lower after a moveDown. Owns the row's alive mask and its current top Y.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   kill1..kill5               erase request per alien, held until the matching cleared pulse
//   moveDown                   shift request, held until clearedShift
//   vgaX, vgaY, colour, plot   registered pixel write; coordinates valid while plot is high
//   cleared1..cleared5         one-cycle kill acknowledges
//   clearedShift               one-cycle shift acknowledge
//   aliveMask, rowY            bit i-1 set while alien i lives; current row top Y
//   busy                       high whenever the renderer is not idle
module alien_row_renderer #(
  parameter int unsigned WIDTH        = 11,
  parameter int unsigned HEIGHT       = 9,
  parameter int unsigned GAP          = 19,
  parameter int unsigned START_X      = 10,
  parameter int unsigned START_Y      = 10,
  parameter int unsigned DROP         = 5,
  parameter int unsigned MAX_Y        = 110,
  parameter logic [2:0]  ALIEN_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kill1,
  input  logic       kill2,
  input  logic       kill3,
  input  logic       kill4,
  input  logic       kill5,
  input  logic       moveDown,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] colour,
  output logic       plot,
  output logic       cleared1,
  output logic       cleared2,
  output logic       cleared3,
  output logic       cleared4,
  output logic       cleared5,
  output logic       clearedShift,
  output logic [4:0] aliveMask,
  output logic [6:0] rowY,
  output logic       busy
);

  localparam logic [2:0] INIT_DRAW   = 3'd0;
  localparam logic [2:0] IDLE        = 3'd1;
  localparam logic [2:0] KILL_ERASE  = 3'd2;
  localparam logic [2:0] KILL_ACK    = 3'd3;
  localparam logic [2:0] SHIFT_ERASE = 3'd4;
  localparam logic [2:0] SHIFT_MOVE  = 3'd5;
  localparam logic [2:0] SHIFT_DRAW  = 3'd6;
  localparam logic [2:0] SHIFT_ACK   = 3'd7;

  // Lowest set bit of m at index >= lo, as {found, index}.
  function automatic logic [3:0] first_from(input logic [4:0] m, input logic [3:0] lo);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i] && (4'(i) >= lo)) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  logic [2:0] state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] alive_q, alive_d;
  logic [6:0] rowy_q, rowy_d;
  logic       armed_q, armed_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic [4:0] clr_q, clr_d;
  logic       clrs_q, clrs_d;

  logic [4:0] kills;
  logic [4:0] scan_mask;
  logic [3:0] next_alien, first_alive, kill_sel;
  logic       step_more;
  logic [3:0] step_col, step_row;
  logic [2:0] step_idx;

  assign kills       = {kill5, kill4, kill3, kill2, kill1};
  assign next_alien  = first_from(scan_mask, {1'b0, idx_q} + 4'd1);
  assign first_alive = first_from(alive_q, 4'd0);
  assign kill_sel    = first_from(kills, 4'd0);

  // Aliens visited by the current raster after the one in progress.
  always_comb begin
    scan_mask = 5'b00000;
    if (state_q == INIT_DRAW) scan_mask = 5'b11111;
    else if (state_q == SHIFT_ERASE || state_q == SHIFT_DRAW) scan_mask = alive_q;
  end

  // Next raster position: column fastest, then row, then next selected alien.
  always_comb begin
    step_more = 1'b1;
    step_col  = 4'd0;
    step_row  = row_q;
    step_idx  = idx_q;
    if (col_q != 4'(WIDTH - 1)) begin
      step_col = col_q + 4'd1;
    end else if (row_q != 4'(HEIGHT - 1)) begin
      step_row = row_q + 4'd1;
    end else if (next_alien[3]) begin
      step_row = 4'd0;
      step_idx = next_alien[2:0];
    end else begin
      step_more = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    idx_d    = idx_q;
    alive_d  = alive_q;
    rowy_d   = rowy_q;
    armed_d  = armed_q;
    plot_d   = 1'b0;
    colour_d = colour_q;
    clr_d    = 5'b00000;
    clrs_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;

    unique case (state_q)
      INIT_DRAW: begin
        if (!plot_q) begin
          // First cycle out of reset: launch alien 0.
          plot_d   = 1'b1;
          colour_d = ALIEN_COLOUR;
          idx_d    = 3'd0;
          col_d    = 4'd0;
          row_d    = 4'd0;
        end else if (step_more) begin
          plot_d = 1'b1;
          {idx_d, row_d, col_d} = {step_idx, step_row, step_col};
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Release interlock: all requests must be seen low before another is taken.
        if ({moveDown, kills} == 6'd0) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          col_d   = 4'd0;
          row_d   = 4'd0;
          if (moveDown) begin
            if (first_alive[3]) begin
              state_d  = SHIFT_ERASE;
              idx_d    = first_alive[2:0];
              plot_d   = 1'b1;
              colour_d = 3'b000;
            end else begin
              state_d = SHIFT_MOVE;
            end
          end else begin
            idx_d = kill_sel[2:0];
            if (alive_q[kill_sel[2:0]]) begin
              state_d  = KILL_ERASE;
              plot_d   = 1'b1;
              colour_d = 3'b000;
            end else begin
              state_d               = KILL_ACK;
              clr_d[kill_sel[2:0]]  = 1'b1;
            end
          end
        end
      end
      KILL_ERASE: begin
        if (step_more) begin
          plot_d = 1'b1;
          {idx_d, row_d, col_d} = {step_idx, step_row, step_col};
        end else begin
          alive_d[idx_q] = 1'b0;
          clr_d[idx_q]   = 1'b1;
          state_d        = KILL_ACK;
        end
      end
      SHIFT_ERASE: begin
        if (step_more) begin
          plot_d = 1'b1;
          {idx_d, row_d, col_d} = {step_idx, step_row, step_col};
        end else begin
          state_d = SHIFT_MOVE;
        end
      end
      SHIFT_MOVE: begin
        if (32'(rowy_q) + DROP >= MAX_Y) rowy_d = 7'(MAX_Y);
        else rowy_d = 7'(32'(rowy_q) + DROP);
        if (first_alive[3]) begin
          state_d  = SHIFT_DRAW;
          idx_d    = first_alive[2:0];
          col_d    = 4'd0;
          row_d    = 4'd0;
          plot_d   = 1'b1;
          colour_d = ALIEN_COLOUR;
        end else begin
          state_d = SHIFT_ACK;
          clrs_d  = 1'b1;
        end
      end
      SHIFT_DRAW: begin
        if (step_more) begin
          plot_d = 1'b1;
          {idx_d, row_d, col_d} = {step_idx, step_row, step_col};
        end else begin
          state_d = SHIFT_ACK;
          clrs_d  = 1'b1;
        end
      end
      KILL_ACK:  state_d = IDLE;
      SHIFT_ACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Coordinates follow the pixel being launched; rowy_d so a fresh draw uses the new row.
    if (plot_d) begin
      x_d = 8'(START_X + 32'(idx_d) * (WIDTH + GAP) + 32'(col_d));
      y_d = 7'(32'(rowy_d) + 32'(row_d));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= INIT_DRAW;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      idx_q    <= 3'd0;
      alive_q  <= 5'b11111;
      rowy_q   <= 7'(START_Y);
      armed_q  <= 1'b1;
      plot_q   <= 1'b0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'b000;
      clr_q    <= 5'b00000;
      clrs_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      alive_q  <= alive_d;
      rowy_q   <= rowy_d;
      armed_q  <= armed_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      clr_q    <= clr_d;
      clrs_q   <= clrs_d;
    end
  end

  assign vgaX         = x_q;
  assign vgaY         = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign cleared1     = clr_q[0];
  assign cleared2     = clr_q[1];
  assign cleared3     = clr_q[2];
  assign cleared4     = clr_q[3];
  assign cleared5     = clr_q[4];
  assign clearedShift = clrs_q;
  assign aliveMask    = alive_q;
  assign rowY         = rowy_q;
  assign busy         = (state_q != IDLE);

endmodule
